// File: rtl/tx_push_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between register-file (1 byte) and ALU (2 byte) frames.
// Optional feature macro: TX_ARB_FRAME_TAG_EN prefixes every frame with a source tag byte.
module tx_push_arbiter #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ALU_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] RF_TAG     = 8'hBB,
    parameter logic [DATA_WIDTH-1:0] ALU_TAG    = 8'hCC
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RF_REQ,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    output logic                  RF_ACK,
    input  logic                  ALU_REQ,
    input  logic [ALU_WIDTH-1:0]  ALU_DATA,
    output logic                  ALU_ACK,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  BUSY
);

    localparam int unsigned HOLD_W = ALU_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef TX_ARB_FRAME_TAG_EN
        ST_TAG   = 2'd1,
`endif
        ST_BYTE0 = 2'd2,
        ST_BYTE1 = 2'd3
    } state_e;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

`ifdef TX_ARB_FRAME_TAG_EN
    localparam state_e FIRST_ST = ST_TAG;
`else
    localparam state_e FIRST_ST = ST_BYTE0;
    // Tag bytes have no consumer when framing tags are compiled out.
    logic unused_tags;
    assign unused_tags = ^{RF_TAG, ALU_TAG};
`endif

    state_e              state_q,    state_d;
    src_e                src_q,      src_d;
    src_e                last_gnt_q, last_gnt_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;
    logic                rf_ack_q,   rf_ack_d;
    logic                alu_ack_q,  alu_ack_d;

    logic                push_c;
    logic                gnt_alu_c;
    logic [DATA_WIDTH-1:0] tx_data_c;

    // State and capture registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_RF;
            last_gnt_q <= SRC_ALU;
            hold_q     <= '0;
            rf_ack_q   <= 1'b0;
            alu_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_gnt_q <= last_gnt_d;
            hold_q     <= hold_d;
            rf_ack_q   <= rf_ack_d;
            alu_ack_q  <= alu_ack_d;
        end
    end

    // Grant, capture and push sequencing; a push state only advances on an accepted push.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_gnt_d = last_gnt_q;
        hold_d     = hold_q;
        rf_ack_d   = 1'b0;
        alu_ack_d  = 1'b0;
        gnt_alu_c  = 1'b0;
        push_c     = (state_q != ST_IDLE) && !FIFO_FULL;

        case (state_q)
            ST_IDLE: begin
                if (RF_REQ || ALU_REQ) begin
                    // On contention the source that did not win last time goes first.
                    gnt_alu_c = ALU_REQ && (!RF_REQ || (last_gnt_q == SRC_RF));
                    if (gnt_alu_c) begin
                        hold_d     = ALU_DATA;
                        src_d      = SRC_ALU;
                        last_gnt_d = SRC_ALU;
                        alu_ack_d  = 1'b1;
                    end else begin
                        hold_d     = HOLD_W'(RF_DATA);
                        src_d      = SRC_RF;
                        last_gnt_d = SRC_RF;
                        rf_ack_d   = 1'b1;
                    end
                    state_d = FIRST_ST;
                end
            end
`ifdef TX_ARB_FRAME_TAG_EN
            ST_TAG: begin
                if (push_c) begin
                    state_d = ST_BYTE0;
                end
            end
`endif
            ST_BYTE0: begin
                if (push_c) begin
                    state_d = (src_q == SRC_ALU) ? ST_BYTE1 : ST_IDLE;
                end
            end
            ST_BYTE1: begin
                if (push_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte selected by the current push state; zero when idle.
    always_comb begin
        tx_data_c = '0;
        case (state_q)
`ifdef TX_ARB_FRAME_TAG_EN
            ST_TAG:   tx_data_c = (src_q == SRC_ALU) ? ALU_TAG : RF_TAG;
`endif
            ST_BYTE0: tx_data_c = hold_q[DATA_WIDTH-1:0];
            ST_BYTE1: tx_data_c = hold_q[HOLD_W-1:DATA_WIDTH];
            default:  tx_data_c = '0;
        endcase
    end

    assign TX_P_DATA = tx_data_c;
    assign TX_D_VLD  = push_c;
    assign BUSY      = (state_q != ST_IDLE);
    assign RF_ACK    = rf_ack_q;
    assign ALU_ACK   = alu_ack_q;

endmodule

// File: tb/tb_tx_push_arbiter.sv
// Directed bench for tx_push_arbiter; expected push streams are written out by hand.
// Tag-byte expectations follow TX_ARB_FRAME_TAG_EN when it is defined for the build.
module tb_tx_push_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RF_REQ;
    logic [7:0]  RF_DATA;
    logic        RF_ACK;
    logic        ALU_REQ;
    logic [15:0] ALU_DATA;
    logic        ALU_ACK;
    logic        FIFO_FULL;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        BUSY;

    int n_vec = 0;
    int n_err = 0;

    tx_push_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .RF_REQ    (RF_REQ),
        .RF_DATA   (RF_DATA),
        .RF_ACK    (RF_ACK),
        .ALU_REQ   (ALU_REQ),
        .ALU_DATA  (ALU_DATA),
        .ALU_ACK   (ALU_ACK),
        .FIFO_FULL (FIFO_FULL),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string nm, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", nm, obs, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", nm, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        settle();
        chk1({nm, "_busy"}, BUSY, 1'b0);
        chk1({nm, "_vld"}, TX_D_VLD, 1'b0);
        chk8({nm, "_data"}, TX_P_DATA, 8'h00);
        chk1({nm, "_rfack"}, RF_ACK, 1'b0);
        chk1({nm, "_aluack"}, ALU_ACK, 1'b0);
    endtask

    // Called in an IDLE cycle with the winning REQ already driven; drops only its own REQ after ACK.
    task automatic serve(input bit alu, input logic [15:0] d, input string nm);
        logic [7:0] exp_b[$];
`ifdef TX_ARB_FRAME_TAG_EN
        exp_b.push_back(alu ? 8'hCC : 8'hBB);
`endif
        exp_b.push_back(d[7:0]);
        if (alu) exp_b.push_back(d[15:8]);
        chk_quiet({nm, "_c0"});
        step();
        for (int i = 0; i < exp_b.size(); i++) begin
            settle();
            chk1($sformatf("%s_rfack%0d", nm, i), RF_ACK, !alu && (i == 0));
            chk1($sformatf("%s_aluack%0d", nm, i), ALU_ACK, alu && (i == 0));
            chk1($sformatf("%s_busy%0d", nm, i), BUSY, 1'b1);
            chk1($sformatf("%s_vld%0d", nm, i), TX_D_VLD, 1'b1);
            chk8($sformatf("%s_data%0d", nm, i), TX_P_DATA, exp_b[i]);
            step();
            if (i == 0) begin
                if (alu) ALU_REQ = 1'b0;
                else     RF_REQ  = 1'b0;
            end
        end
    endtask

    // Runs an ALU 0x1234 frame up to the first cycle in BYTE1.
    task automatic alu_to_byte1(input string nm);
        ALU_DATA = 16'h1234;
        ALU_REQ  = 1'b1;
        chk_quiet({nm, "_c0"});
        step();
`ifdef TX_ARB_FRAME_TAG_EN
        settle();
        chk1({nm, "_ack"}, ALU_ACK, 1'b1);
        chk8({nm, "_tag"}, TX_P_DATA, 8'hCC);
        step();
        ALU_REQ = 1'b0;
        settle();
        chk1({nm, "_vld0"}, TX_D_VLD, 1'b1);
        chk8({nm, "_b0"}, TX_P_DATA, 8'h34);
        step();
`else
        settle();
        chk1({nm, "_ack"}, ALU_ACK, 1'b1);
        chk1({nm, "_vld0"}, TX_D_VLD, 1'b1);
        chk8({nm, "_b0"}, TX_P_DATA, 8'h34);
        step();
        ALU_REQ = 1'b0;
`endif
    endtask

    task automatic do_reset();
        RST       = 1'b0;
        RF_REQ    = 1'b0;
        ALU_REQ   = 1'b0;
        FIFO_FULL = 1'b0;
        RF_DATA   = 8'h00;
        ALU_DATA  = 16'h0000;
        chk_quiet("rst");
        step();
        step();
        RST = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single RF frame, then single ALU frame back to back.
        RF_DATA = 8'h5A;
        RF_REQ  = 1'b1;
        serve(1'b0, 16'h005A, "rf5a");
        ALU_DATA = 16'h1234;
        ALU_REQ  = 1'b1;
        serve(1'b1, 16'h1234, "alu1234");
        chk_quiet("after_alu");

        // Simultaneous requests right after reset: RF first, then ALU beats a re-raised RF.
        do_reset();
        RF_DATA  = 8'hA5;
        ALU_DATA = 16'hBEEF;
        RF_REQ   = 1'b1;
        ALU_REQ  = 1'b1;
        serve(1'b0, 16'h00A5, "pair1_rf");
        RF_DATA = 8'h3C;
        RF_REQ  = 1'b1;
        serve(1'b1, 16'hBEEF, "pair2_alu");
        serve(1'b0, 16'h003C, "pair2_rf");

        // Stall for three cycles while in BYTE1.
        alu_to_byte1("stall");
        FIFO_FULL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk1($sformatf("stall_vld%0d", k), TX_D_VLD, 1'b0);
            chk8($sformatf("stall_data%0d", k), TX_P_DATA, 8'h12);
            chk1($sformatf("stall_busy%0d", k), BUSY, 1'b1);
            step();
        end
        FIFO_FULL = 1'b0;
        settle();
        chk1("stall_release_vld", TX_D_VLD, 1'b1);
        chk8("stall_release_data", TX_P_DATA, 8'h12);
        step();
        chk_quiet("stall_done");

        // FIFO full while idle still grants; push waits for FIFO_FULL to fall.
        RF_DATA   = 8'h81;
        RF_REQ    = 1'b1;
        FIFO_FULL = 1'b1;
        settle();
        step();
        settle();
        chk1("fullidle_ack", RF_ACK, 1'b1);
        chk1("fullidle_busy", BUSY, 1'b1);
        chk1("fullidle_vld", TX_D_VLD, 1'b0);
`ifdef TX_ARB_FRAME_TAG_EN
        chk8("fullidle_data", TX_P_DATA, 8'hBB);
`else
        chk8("fullidle_data", TX_P_DATA, 8'h81);
`endif
        step();
        RF_REQ    = 1'b0;
        FIFO_FULL = 1'b0;
        settle();
        chk1("fullidle_ack2", RF_ACK, 1'b0);
        chk1("fullidle_vld2", TX_D_VLD, 1'b1);
`ifdef TX_ARB_FRAME_TAG_EN
        chk8("fullidle_tag", TX_P_DATA, 8'hBB);
        step();
        settle();
        chk1("fullidle_vld3", TX_D_VLD, 1'b1);
        chk8("fullidle_data3", TX_P_DATA, 8'h81);
`else
        chk8("fullidle_data2", TX_P_DATA, 8'h81);
`endif
        step();
        chk_quiet("fullidle_done");

        // Reset after the low byte of an ALU frame drops the high byte.
        alu_to_byte1("midrst");
        RST = 1'b0;
        chk_quiet("midrst_now");
        step();
        RST = 1'b1;
        chk_quiet("midrst_rel");
        step();
        chk_quiet("midrst_nopush");
        RF_DATA = 8'h66;
        RF_REQ  = 1'b1;
        serve(1'b0, 16'h0066, "post_rst_rf");
        chk_quiet("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
